mult_operand_sequencer: RTL and testbench

//  Upstream/downstream sequencer around the 4x4 combinational array multiplier.

---
 rtl/mult_operand_sequencer.sv | 127 ++++++++++++
 tb/tb_mult_operand_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mult_operand_sequencer.sv
// mult_operand_sequencer: nibble-stream operand loader, settle timer and product register for a 4x4 array multiplier.
// Define MULT_SEQ_SKID_EN to replace the single result register with a 2-entry result FIFO.
module mult_operand_sequencer #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_data,
    output logic [WIDTH-1:0]   mult_m,
    output logic [WIDTH-1:0]   mult_q,
    input  logic [2*WIDTH-1:0] mult_p,
    output logic               busy
);
    if (WIDTH != 4) begin : g_bad_width
        $error("mult_operand_sequencer: WIDTH must be 4");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("mult_operand_sequencer: SETTLE_CYCLES must be 1..15");
    end
    typedef enum logic [1:0] {LOAD_M, LOAD_Q, SETTLE, RESULT} state_t;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    state_t st_q, st_d;
    logic [3:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] m_q, m_d, qo_q, qo_d;
    logic push_ok, settle_done, out_xfer;
    assign in_ready    = (st_q == LOAD_M) || (st_q == LOAD_Q);
    assign out_xfer    = out_valid & out_ready;
    assign settle_done = (st_q == SETTLE) && (cnt_q == 4'd0) && push_ok;
    assign busy        = (st_q == SETTLE) | out_valid;
    assign mult_m      = m_q;
    assign mult_q      = qo_q;
`ifdef MULT_SEQ_SKID_EN
    logic [2*WIDTH-1:0] mem_q [2];
    logic [2*WIDTH-1:0] mem_d [2];
    logic       rd_q, rd_d;
    logic [1:0] cntf_q, cntf_d;
    logic       wr;
    // A full FIFO can still accept a push when its head leaves in the same cycle.
    assign push_ok   = (cntf_q != 2'd2) | out_xfer;
    assign wr        = rd_q ^ cntf_q[0];
    assign out_valid = cntf_q != 2'd0;
    assign out_data  = mem_q[rd_q];
    always_comb begin
        mem_d = mem_q;
        if (settle_done) mem_d[wr] = mult_p;
        rd_d   = rd_q ^ out_xfer;
        cntf_d = cntf_q + 2'(settle_done) - 2'(out_xfer);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_q     <= 1'b0;
            cntf_q   <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            rd_q   <= rd_d;
            cntf_q <= cntf_d;
        end
    end
`else
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               vld_q, vld_d;
    assign push_ok   = 1'b1;
    assign out_valid = vld_q;
    assign out_data  = res_q;
    always_comb begin
        res_d = settle_done ? mult_p : res_q;
        vld_d = settle_done ? 1'b1 : out_xfer ? 1'b0 : vld_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
            vld_q <= 1'b0;
        end else begin
            res_q <= res_d;
            vld_q <= vld_d;
        end
    end
`endif
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        m_d   = m_q;
        qo_d  = qo_q;
        case (st_q)
            LOAD_M: if (in_valid) begin
                m_d  = in_data;
                st_d = LOAD_Q;
            end
            LOAD_Q: if (in_valid) begin
                qo_d  = in_data;
                cnt_d = CNT_INIT;
                st_d  = SETTLE;
            end
            SETTLE: begin
                if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
`ifdef MULT_SEQ_SKID_EN
                else if (settle_done) st_d = LOAD_M;
`else
                else if (settle_done) st_d = RESULT;
`endif
            end
            RESULT: st_d = out_xfer ? LOAD_M : RESULT;
            default: st_d = LOAD_M;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= LOAD_M;
            cnt_q <= 4'd0;
            m_q   <= '0;
            qo_q  <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
            m_q   <= m_d;
            qo_q  <= qo_d;
        end
    end
endmodule

// File: tb/tb_mult_operand_sequencer.sv
// tb_mult_operand_sequencer: directed checks of the operand sequencer with SETTLE_CYCLES=1 and =4 instances.
module tb_mult_operand_sequencer;
    logic clk = 1'b0;
    logic rst, in_valid, out_ready;
    logic [3:0] in_data;
    logic in_ready, out_valid, busy;
    logic [7:0] out_data, mult_p;
    logic [3:0] mult_m, mult_q;
    logic in_ready4, out_valid4, busy4;
    logic [7:0] out_data4, mult_p4;
    logic [3:0] mult_m4, mult_q4;
    int n_tests = 0;
    int n_fail  = 0;
    always #5 clk = ~clk;
    assign mult_p  = {4'd0, mult_m} * {4'd0, mult_q};
    assign mult_p4 = {4'd0, mult_m4} * {4'd0, mult_q4};
    mult_operand_sequencer #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mult_m(mult_m), .mult_q(mult_q), .mult_p(mult_p), .busy(busy)
    );
    mult_operand_sequencer #(.WIDTH(4), .SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .mult_m(mult_m4), .mult_q(mult_q4), .mult_p(mult_p4), .busy(busy4)
    );
`ifdef MULT_SEQ_SKID_EN
    localparam logic HOLD_READY = 1'b1;
`else
    localparam logic HOLD_READY = 1'b0;
`endif
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [3:0] v);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
        in_data  = 4'h0;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask
    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b0;
        do_reset();
        check("rst_out_valid", 8'(out_valid), 8'd0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_mult_m", 8'(mult_m), 8'd0);
        check("rst_mult_q", 8'(mult_q), 8'd0);
        check("rst_in_ready", 8'(in_ready), 8'd1);
        check("rst_busy", 8'(busy), 8'd0);
        out_ready = 1'b1;
        send(4'hF);
        send(4'hF);
        check("ff_settle_busy", 8'(busy), 8'd1);
        check("ff_settle_valid", 8'(out_valid), 8'd0);
        check("ff_settle_ready", 8'(in_ready), 8'd0);
        tick();
        check("ff_valid", 8'(out_valid), 8'd1);
        check("ff_data", out_data, 8'hE1);
        tick();
        check("ff_consumed", 8'(out_valid), 8'd0);
        check("ff_ready_again", 8'(in_ready), 8'd1);
        out_ready = 1'b0;
        send(4'h7);
        for (int i = 0; i < 5; i++) tick();
        check("idle_mult_m", 8'(mult_m), 8'h07);
        check("idle_in_ready", 8'(in_ready), 8'd1);
        send(4'h9);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("hold_data", out_data, 8'h3F);
            check("hold_valid", 8'(out_valid), 8'd1);
            check("hold_in_ready", 8'(in_ready), 8'(HOLD_READY));
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("hold_released", 8'(out_valid), 8'd0);
        out_ready = 1'b0;
        send(4'h3);
        check("pre_rst_mult_m", 8'(mult_m), 8'h03);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_mult_m", 8'(mult_m), 8'd0);
        check("mid_rst_in_ready", 8'(in_ready), 8'd1);
        send(4'h2);
        send(4'h6);
        tick();
        check("after_rst_data", out_data, 8'h0C);
        check("after_rst_mult_m", 8'(mult_m), 8'h02);
        check("after_rst_mult_q", 8'(mult_q), 8'h06);
        out_ready = 1'b1;
        tick();
        check("after_rst_single", 8'(out_valid), 8'd0);
        do_reset();
        send(4'hA);
        send(4'hC);
        check("s4_busy", 8'(busy4), 8'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("s4_not_yet", 8'(out_valid4), 8'd0);
        end
        tick();
        check("s4_valid", 8'(out_valid4), 8'd1);
        check("s4_data", out_data4, 8'h78);
        tick();
        check("s4_consumed", 8'(out_valid4), 8'd0);
        check("s4_idle_busy", 8'(busy4), 8'd0);
`ifdef MULT_SEQ_SKID_EN
        out_ready = 1'b0;
        do_reset();
        send(4'h2);
        send(4'h3);
        tick();
        check("skid_first", out_data, 8'h06);
        send(4'h4);
        send(4'h5);
        tick();
        check("skid_second_ready", 8'(in_ready), 8'd1);
        send(4'h6);
        send(4'h7);
        tick();
        check("skid_stall_ready", 8'(in_ready), 8'd0);
        check("skid_stall_busy", 8'(busy), 8'd1);
        tick();
        check("skid_still_stalled", 8'(in_ready), 8'd0);
        check("skid_head", out_data, 8'h06);
        out_ready = 1'b1;
        tick();
        check("skid_order1", out_data, 8'h14);
        check("skid_unstalled", 8'(in_ready), 8'd1);
        tick();
        check("skid_order2", out_data, 8'h2A);
        tick();
        check("skid_empty", 8'(out_valid), 8'd0);
        out_ready = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
